// File: rtl/operand_router_if.sv
// Handshake and operand bus between decode, operand_router and the ALU/condition stage.
// master = decode/consumer side driving instruction fields, slave = operand_router.
interface operand_router_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] opcode2;
  logic [DATA_W-1:0] opcode3;
  logic [ADDR_W-1:0] opcode4;
  logic [2:0]        src1_sel;
  logic [2:0]        src2_sel;
  logic [DATA_W-1:0] io_in;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] stack_data;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_value;
  logic              branch_taken;
  logic              is_ret;
  logic              err_clr;
  logic [DATA_W-1:0] arg1;
  logic [DATA_W-1:0] arg2;
  logic              out_valid;
  logic              out_ready;
  logic              out_err;
  logic [ADDR_W-1:0] pc;
  logic              halted;

  modport master (
    output in_valid, opcode2, opcode3, opcode4, src1_sel, src2_sel,
           io_in, ram_data, stack_data, pc_load, pc_load_value,
           branch_taken, is_ret, err_clr, out_ready,
    input  in_ready, arg1, arg2, out_valid, out_err, pc, halted
  );

  modport slave (
    input  in_valid, opcode2, opcode3, opcode4, src1_sel, src2_sel,
           io_in, ram_data, stack_data, pc_load, pc_load_value,
           branch_taken, is_ret, err_clr, out_ready,
    output in_ready, arg1, arg2, out_valid, out_err, pc, halted
  );
endinterface

// File: rtl/operand_router.sv
// Registered two-operand source mux plus program counter for the model computer datapath.
// Define ROUTER_HALT_EN to halt on a reserved selector until err_clr is pulsed.
module operand_router #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned INSTR_BYTES = 4
) (
  input logic             clk,
  input logic             rst_n,
  operand_router_if.slave bus
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t            state;
  logic [DATA_W-1:0] arg1_q;
  logic [DATA_W-1:0] arg2_q;
  logic              out_valid_q;
  logic              out_err_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_next;
  logic [DATA_W:0]   op1;
  logic [DATA_W:0]   op2;
  logic              in_ready_c;
  logic              xfer;

  // Returns {reserved_flag, data}; the pc source is the pre-update PC.
  function automatic logic [DATA_W:0] pick(
    input logic [2:0]        sel,
    input logic [DATA_W-1:0] imm,
    input logic [ADDR_W-1:0] pcv,
    input logic [DATA_W-1:0] io,
    input logic [DATA_W-1:0] ram,
    input logic [DATA_W-1:0] stk
  );
    case (sel)
      3'd0:    pick = {1'b0, imm};
      3'd1:    pick = {1'b0, DATA_W'(pcv)};
      3'd2:    pick = {1'b0, io};
      3'd3:    pick = {1'b0, ram};
      3'd4:    pick = {1'b0, stk};
      default: pick = {1'b1, {DATA_W{1'b0}}};
    endcase
  endfunction

  assign in_ready_c = (state == RUN) && (!out_valid_q || bus.out_ready);
  assign xfer       = bus.in_valid && in_ready_c;

  always_comb begin
    op1 = pick(bus.src1_sel, bus.opcode2, pc_q, bus.io_in, bus.ram_data, bus.stack_data);
    op2 = pick(bus.src2_sel, bus.opcode3, pc_q, bus.io_in, bus.ram_data, bus.stack_data);
  end

  // Load beats return, return beats branch, branch beats sequential increment.
  always_comb begin
    pc_next = pc_q + ADDR_W'(INSTR_BYTES);
    if (bus.pc_load)
      pc_next = bus.pc_load_value;
    else if (bus.branch_taken && bus.is_ret)
      pc_next = ADDR_W'(bus.stack_data);
    else if (bus.branch_taken)
      pc_next = bus.opcode4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      arg1_q      <= '0;
      arg2_q      <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      pc_q        <= '0;
    end else begin
      if (xfer) begin
        arg1_q      <= op1[DATA_W-1:0];
        arg2_q      <= op2[DATA_W-1:0];
        out_err_q   <= op1[DATA_W] | op2[DATA_W];
        out_valid_q <= 1'b1;
        pc_q        <= pc_next;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
`ifdef ROUTER_HALT_EN
      if ((state == RUN) && xfer && (op1[DATA_W] || op2[DATA_W]))
        state <= HALT;
      else if ((state == HALT) && bus.err_clr)
        state <= RUN;
`else
      state <= RUN;
`endif
    end
  end

`ifndef ROUTER_HALT_EN
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.arg1      = arg1_q;
  assign bus.arg2      = arg2_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_err   = out_err_q;
  assign bus.pc        = pc_q;
  assign bus.halted    = (state == HALT);

endmodule

// File: tb/tb_operand_router.sv
// Directed scoreboard bench for operand_router; follows ROUTER_HALT_EN when it is defined.
module tb_operand_router;

`ifdef ROUTER_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  operand_router_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  operand_router #(.DATA_W(8), .ADDR_W(8), .INSTR_BYTES(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [16:0] sb[$];   // {out_err, arg1, arg2}
  logic [7:0]  m_pc;
  logic        m_ov;
  logic        m_halt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ref_op(input logic [2:0] sel, input logic [7:0] imm);
    case (sel)
      3'd0:    return {1'b0, imm};
      3'd1:    return {1'b0, m_pc};
      3'd2:    return {1'b0, bus.io_in};
      3'd3:    return {1'b0, bus.ram_data};
      3'd4:    return {1'b0, bus.stack_data};
      default: return 9'h100;
    endcase
  endfunction

  // Called just after a falling edge with inputs set; checks, updates the model, advances one clock.
  task automatic cycle();
    logic        exp_rdy;
    logic        xfer;
    logic [8:0]  e1;
    logic [8:0]  e2;
    logic [16:0] head;
    #1;
    exp_rdy = !m_halt && (!m_ov || bus.out_ready);
    chk("in_ready",  32'(bus.in_ready),  32'(exp_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    chk("pc",        32'(bus.pc),        32'(m_pc));
    chk("halted",    32'(bus.halted),    32'(m_halt));
    if (m_ov && bus.out_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        head = sb.pop_front();
        chk("arg1",    32'(bus.arg1),    32'(head[15:8]));
        chk("arg2",    32'(bus.arg2),    32'(head[7:0]));
        chk("out_err", 32'(bus.out_err), 32'(head[16]));
      end
    end
    xfer = bus.in_valid && exp_rdy;
    if (m_halt && bus.err_clr) begin
      m_halt = 1'b0;
    end else if (xfer) begin
      e1 = ref_op(bus.src1_sel, bus.opcode2);
      e2 = ref_op(bus.src2_sel, bus.opcode3);
      sb.push_back({e1[8] | e2[8], e1[7:0], e2[7:0]});
      m_ov = 1'b1;
      if (HALT_EN && (e1[8] || e2[8])) m_halt = 1'b1;
      if (bus.pc_load)                          m_pc = bus.pc_load_value;
      else if (bus.branch_taken && bus.is_ret)  m_pc = bus.stack_data;
      else if (bus.branch_taken)                m_pc = bus.opcode4;
      else                                      m_pc = m_pc + 8'd4;
    end
    if (!xfer && bus.out_ready) m_ov = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.in_valid      = 1'b0;
    bus.opcode2       = 8'h00;
    bus.opcode3       = 8'h00;
    bus.opcode4       = 8'h00;
    bus.src1_sel      = 3'd0;
    bus.src2_sel      = 3'd0;
    bus.io_in         = 8'h00;
    bus.ram_data      = 8'h00;
    bus.stack_data    = 8'h00;
    bus.pc_load       = 1'b0;
    bus.pc_load_value = 8'h00;
    bus.branch_taken  = 1'b0;
    bus.is_ret        = 1'b0;
    bus.err_clr       = 1'b0;
    bus.out_ready     = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    m_pc = 8'h00; m_ov = 1'b0; m_halt = 1'b0;
    #3;
    chk("rst_arg1",      32'(bus.arg1),      32'(0));
    chk("rst_arg2",      32'(bus.arg2),      32'(0));
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out_err",   32'(bus.out_err),   32'(0));
    chk("rst_pc",        32'(bus.pc),        32'(0));
    chk("rst_halted",    32'(bus.halted),    32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Immediate and PC operands, back to back
    bus.in_valid = 1'b1; bus.src1_sel = 3'd0; bus.opcode2 = 8'h11; bus.src2_sel = 3'd1;
    repeat (3) cycle();
    bus.in_valid = 1'b0;
    chk("pc_after3", 32'(bus.pc), 32'(8'h0C));
    cycle();

    // PC wraps past 0xFC
    bus.in_valid = 1'b1; bus.pc_load = 1'b1; bus.pc_load_value = 8'hFC;
    cycle();
    bus.pc_load = 1'b0;
    cycle();
    chk("pc_wrap", 32'(bus.pc), 32'(8'h00));

    // PC update priority and return
    bus.pc_load = 1'b1; bus.pc_load_value = 8'h40; bus.branch_taken = 1'b1; bus.opcode4 = 8'h80;
    cycle();
    chk("pc_load_wins", 32'(bus.pc), 32'(8'h40));
    bus.pc_load = 1'b0; bus.is_ret = 1'b1; bus.stack_data = 8'h22;
    cycle();
    chk("pc_ret", 32'(bus.pc), 32'(8'h22));
    bus.is_ret = 1'b0;
    cycle();
    chk("pc_branch", 32'(bus.pc), 32'(8'h80));
    bus.branch_taken = 1'b0; bus.is_ret = 1'b1;
    cycle();
    chk("pc_ret_ignored", 32'(bus.pc), 32'(8'h84));
    bus.is_ret = 1'b0;

    // Remaining sources
    bus.src1_sel = 3'd2; bus.io_in = 8'h5A; bus.src2_sel = 3'd3; bus.ram_data = 8'hA5;
    cycle();
    bus.src1_sel = 3'd4; bus.stack_data = 8'h3C; bus.src2_sel = 3'd0; bus.opcode3 = 8'h77;
    cycle();
    bus.src1_sel = 3'd1; bus.src2_sel = 3'd4; bus.stack_data = 8'hC3;
    cycle();
    bus.in_valid = 1'b0;
    cycle();

    // Backpressure holds output and PC
    bus.in_valid = 1'b1; bus.src1_sel = 3'd0; bus.opcode2 = 8'hAA; bus.src2_sel = 3'd0;
    bus.opcode3 = 8'h55; bus.out_ready = 1'b0;
    cycle();
    bus.opcode2 = 8'hBB; bus.opcode3 = 8'h66;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_arg1", 32'(bus.arg1), 32'(8'hAA));
      chk("hold_arg2", 32'(bus.arg2), 32'(8'h55));
    end
    bus.out_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    cycle();

    // Reserved selector
    bus.in_valid = 1'b1; bus.opcode2 = 8'h12; bus.src2_sel = 3'd6;
    cycle();
    chk("err_arg2",    32'(bus.arg2),    32'(0));
    chk("err_out_err", 32'(bus.out_err), 32'(1));
    bus.src2_sel = 3'd0; bus.opcode3 = 8'h34;
    repeat (2) cycle();
    bus.in_valid = 1'b0; bus.err_clr = 1'b1;
    cycle();
    bus.err_clr = 1'b0; bus.in_valid = 1'b1; bus.src1_sel = 3'd5; bus.src2_sel = 3'd1;
    cycle();
    bus.err_clr = 1'b1; bus.in_valid = 1'b0; bus.src1_sel = 3'd0;
    cycle();
    bus.err_clr = 1'b0; bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    chk("sb_drained", 32'(sb.size()), 32'(0));

    // Asynchronous reset drops pending output
    bus.in_valid = 1'b1; bus.pc_load = 1'b1; bus.pc_load_value = 8'h30;
    bus.opcode2 = 8'h99; bus.out_ready = 1'b0;
    cycle();
    bus.in_valid = 1'b0; bus.pc_load = 1'b0;
    #2;
    chk("pre_rst_pc",        32'(bus.pc),        32'(8'h30));
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 32'(0));
    chk("async_pc",        32'(bus.pc),        32'(0));
    chk("async_arg1",      32'(bus.arg1),      32'(0));
    sb.delete();
    m_pc = 8'h00; m_ov = 1'b0; m_halt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    bus.src1_sel = 3'd1; bus.src2_sel = 3'd0; bus.opcode3 = 8'h5E;
    repeat (2) cycle();
    bus.in_valid = 1'b0;
    cycle();
    chk("final_drained", 32'(sb.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
